// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and the PWM duty meter.
//   PWM_PERIOD    : nominal PWM period in clock cycles (duty of PWM_PERIOD = 100 % high)
//   PWM_DUTY_W    : width of duty / count values; 2**PWM_DUTY_W must exceed PWM_PERIOD
//   meter_state_t : duty meter window alignment state
package pwm_pkg;

  localparam int PWM_PERIOD = 50;
  localparam int PWM_DUTY_W = 6;

  typedef enum logic {
    SEEK = 1'b0,
    LOCK = 1'b1
  } meter_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for the PWM duty meter: a SYNC_STAGES-deep synchronizer
// for the asynchronous PWM line followed by a one-cycle delay flop used for
// rising-edge detection.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-low reset (clears every flop)
//   pwm_in : asynchronous PWM line
//   pwm_s  : synchronized line, SYNC_STAGES cycles after pwm_in
//   rise   : one-cycle pulse on the first synchronized high sample after a low
module pwm_in_sync
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   pwm_d_q;
  logic                   pwm_d_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
    pwm_d_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= '0;
      pwm_d_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pwm_d_q <= pwm_d_d;
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  // The delay flop clears to 0, so a line already high out of reset still
  // yields a rise on its first synchronized high sample.
  assign rise  = pwm_s & ~pwm_d_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures the high time of an incoming PWM line, in clock
// cycles, over each PERIOD-cycle window and reports it with a one-cycle strobe.
// Windows align to rising edges while locked; without an aligned rise they
// free-run and close on a PERIOD-cycle timeout.
// Ports:
//   clock      : rising-edge clock
//   reset      : synchronous, active-low reset
//   pwm_in     : asynchronous PWM line to measure
//   duty       : high cycles in the last completed window (held between strobes)
//   duty_valid : one-cycle pulse when duty / period_err update
//   period_err : 1 when the last window closed on a rise before PERIOD cycles
//   locked     : 1 while windows are aligned to rising edges
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int DUTY_W      = PWM_DUTY_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              period_err,
  output logic              locked
);

  localparam logic [DUTY_W-1:0] PERIOD_C = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] ONE_C    = DUTY_W'(1);

  logic pwm_s;
  logic rise;

  meter_state_t      state_q,      state_d;
  logic [DUTY_W-1:0] period_cnt_q, period_cnt_d;
  logic [DUTY_W-1:0] high_cnt_q,   high_cnt_d;
  logic [DUTY_W-1:0] duty_q,       duty_d;
  logic              duty_valid_q, duty_valid_d;
  logic              period_err_q, period_err_d;
  logic [DUTY_W-1:0] pwm_s_ext;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_in_sync (
    .clock (clock),
    .reset (reset),
    .pwm_in(pwm_in),
    .pwm_s (pwm_s),
    .rise  (rise)
  );

  assign pwm_s_ext = {{(DUTY_W-1){1'b0}}, pwm_s};

  // high_cnt <= period_cnt <= PERIOD holds at all times, so the counters
  // never need saturation or wrap handling.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q + ONE_C;
    high_cnt_d   = high_cnt_q + pwm_s_ext;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    period_err_d = period_err_q;

    if (rise) begin
      // A rise always starts a new aligned window. Only a window that was
      // itself opened by a rise is complete enough to report.
      if (state_q == LOCK) begin
        duty_d       = high_cnt_q;
        period_err_d = (period_cnt_q != PERIOD_C);
        duty_valid_d = 1'b1;
      end
      period_cnt_d = ONE_C;
      high_cnt_d   = ONE_C;
      state_d      = LOCK;
    end else if (period_cnt_q == PERIOD_C) begin
      // Timeout: a compliant signal would have risen in this cycle, so lock
      // is lost and windows free-run. The current sample opens the next one.
      duty_d       = high_cnt_q;
      period_err_d = 1'b0;
      duty_valid_d = 1'b1;
      period_cnt_d = ONE_C;
      high_cnt_d   = pwm_s_ext;
      state_d      = SEEK;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= SEEK;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      period_err_q <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      period_err_q <= period_err_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign period_err = period_err_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Testbench for pwm_duty_meter. Each phase resets the meter, drives a directed
// PWM pattern, and queues the hand-computed strobes (edge index, duty,
// period_err, locked). A monitor pops and compares on every duty_valid.
//
// Timing reference: edge 0 is the first rising edge with reset released, and
// pwm_in for edge j is driven before edge j. The counter sees that sample two
// edges later, so for a pattern starting high the first rise is seen at edge 2.
module tb_pwm_duty_meter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pwm_in = 1'b0;
  logic [5:0] duty;
  logic       duty_valid;
  logic       period_err;
  logic       locked;

  pwm_duty_meter #(
    .PERIOD     (50),
    .DUTY_W     (6),
    .SYNC_STAGES(2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .duty_valid(duty_valid),
    .period_err(period_err),
    .locked    (locked)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic [5:0] duty;
    logic       err;
    logic       lck;
  } exp_t;

  exp_t sb[$];
  exp_t pend[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (duty_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe with duty %0d at cycle %0d expected none",
                 duty, cyc);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.stamp);
        check("duty", {26'd0, duty}, {26'd0, e.duty});
        check("period_err", {31'd0, period_err}, {31'd0, e.err});
        check("locked_at_strobe", {31'd0, locked}, {31'd0, e.lck});
      end
    end
  end

  function automatic logic pat(input int kind, input int j);
    case (kind)
      0:       return ((j % 50) < 25);  // duty 25 / period 50
      1:       return ((j % 50) < 10);  // duty 10 / period 50
      2:       return 1'b1;             // steady high
      3:       return 1'b0;             // steady low
      default: return ((j % 30) < 10);  // short period: 10 high / 20 low
    endcase
  endfunction

  task automatic expect_at(input int edge_n, input int d, input logic err, input logic lck);
    exp_t e;
    e.stamp = edge_n;
    e.duty  = 6'(d);
    e.err   = err;
    e.lck   = lck;
    pend.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_duty_valid"}, {31'd0, duty_valid}, 32'd0);
    check({tag, "_duty"}, {26'd0, duty}, 32'd0);
    check({tag, "_period_err"}, {31'd0, period_err}, 32'd0);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
  endtask

  // Two reset edges, then confirm the previous phase delivered every strobe
  // and that all outputs are cleared.
  task automatic reset_and_audit(input string tag);
    @(negedge clock);
    reset  = 1'b0;
    pwm_in = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    check({tag, "_missing_strobes"}, sb.size(), 32'd0);
    check_outputs_zero({tag, "_reset"});
  endtask

  task automatic run_phase(input string tag, input int kind, input int n, input int rst_at);
    int base;
    reset_and_audit(tag);
    base = cyc;
    foreach (pend[i]) begin
      exp_t e;
      e       = pend[i];
      e.stamp = base + e.stamp + 1;
      sb.push_back(e);
    end
    pend.delete();
    reset  = 1'b1;
    pwm_in = pat(kind, 0);
    for (int j = 1; j < n; j++) begin
      @(negedge clock);
      if (rst_at > 0) begin
        if (j == rst_at + 2) check_outputs_zero("midreset_in_reset");
        if (j == 102) check("midreset_prelock_locked", {31'd0, locked}, 32'd0);
        if (j == 120) begin
          check("midreset_relock_locked", {31'd0, locked}, 32'd1);
          check("midreset_relock_duty", {26'd0, duty}, 32'd0);
        end
      end
      reset  = (rst_at > 0 && j >= rst_at && j < rst_at + 3) ? 1'b0 : 1'b1;
      pwm_in = pat(kind, j);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Duty 25: first rise (edge 2) only locks; strobes every 50 cycles.
    expect_at(52, 25, 1'b0, 1'b1);
    expect_at(102, 25, 1'b0, 1'b1);
    expect_at(152, 25, 1'b0, 1'b1);
    run_phase("duty25", 0, 200, 0);

    // Duty 10.
    expect_at(52, 10, 1'b0, 1'b1);
    expect_at(102, 10, 1'b0, 1'b1);
    expect_at(152, 10, 1'b0, 1'b1);
    run_phase("duty10", 1, 200, 0);

    // Steady high: rise at edge 2, then timeouts every 50 cycles, unlocked.
    expect_at(52, 50, 1'b0, 1'b0);
    expect_at(102, 50, 1'b0, 1'b0);
    expect_at(152, 50, 1'b0, 1'b0);
    run_phase("steady_high", 2, 200, 0);

    // Steady low: no rise; period_cnt starts at 0, so first timeout at edge 50.
    expect_at(50, 0, 1'b0, 1'b0);
    expect_at(100, 0, 1'b0, 1'b0);
    expect_at(150, 0, 1'b0, 1'b0);
    run_phase("steady_low", 3, 200, 0);

    // Short period of 30: each later rise reports duty 10 with period_err.
    expect_at(32, 10, 1'b1, 1'b1);
    expect_at(62, 10, 1'b1, 1'b1);
    expect_at(92, 10, 1'b1, 1'b1);
    run_phase("short_period", 4, 100, 0);

    // Duty 25 with reset held over edges 82..84 (cycle 30 of the window that
    // opened at edge 52). The aborted window emits nothing; the rise at edge
    // 102 relocks and the rise at edge 152 reports again.
    expect_at(52, 25, 1'b0, 1'b1);
    expect_at(152, 25, 1'b0, 1'b1);
    run_phase("midreset", 0, 200, 82);

    reset_and_audit("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
